// File: rtl/atanh_cordic.sv
// atanh_cordic: y = atanh(x) for sign-magnitude Q(N-Q).Q operands using an
// iterative hyperbolic CORDIC in vectoring mode, one operand in flight.
module atanh_cordic #(
    parameter int unsigned     N     = 32,
    parameter int unsigned     Q     = 24,
    parameter int unsigned     ITER  = 24,
    parameter int unsigned     GUARD = 4,
    parameter logic [N-1:0]    LIMIT = 32'h00CE_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         ovr
);

    localparam int unsigned W    = N + GUARD + 1;
    localparam int unsigned FRAC = Q + GUARD;
    localparam int unsigned IWR  = $clog2(ITER + 2);
    localparam int unsigned IW   = (IWR < 5) ? 5 : IWR;
    // Table below is held at 2^-28 resolution and rescaled to FRAC bits.
    localparam int unsigned UP   = (FRAC >= 28) ? FRAC - 28 : 0;
    localparam int unsigned DN   = (FRAC < 28) ? 28 - FRAC : 0;
    localparam logic [W-1:0] RND     = {{(W-1){1'b0}}, 1'b1} << (GUARD - 1);
    localparam logic [W-1:0] MAG_MAX = {{(GUARD+2){1'b0}}, {(N-1){1'b1}}};

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic                  sign_q, sign_d;
    logic signed [W-1:0]   cx_q, cx_d;
    logic signed [W-1:0]   cy_q, cy_d;
    logic signed [W-1:0]   cz_q, cz_d;
    logic [IW-1:0]         it_q, it_d;
    logic                  rep_q, rep_d;
    logic [N-1:0]          y_q, y_d;
    logic                  ovr_q, ovr_d;

    logic signed [W-1:0]   shx, shy, step_z;
    logic [W-1:0]          e_i, z_rnd, z_sh, mag_w;
    logic                  rep_now, last_iter;

    // atanh(2^-i) scaled to FRAC fractional bits; beyond i=11 the cubic
    // term is below one LSB at 2^-28, so 2^-i is exact enough.
    function automatic logic [W-1:0] atanh_e(input logic [IW-1:0] idx);
        logic [63:0]  base;
        int unsigned  k;
        k = 32'(idx);
        case (k)
            1:  base = 64'd147453245;
            2:  base = 64'd68561855;
            3:  base = 64'd33730852;
            4:  base = 64'd16799113;
            5:  base = 64'd8391340;
            6:  base = 64'd4194645;
            7:  base = 64'd2097195;
            8:  base = 64'd1048581;
            9:  base = 64'd524289;
            10: base = 64'd262144;
            11: base = 64'd131072;
            default: base = (k <= 28) ? (64'd1 << (28 - k)) : 64'd0;
        endcase
        base = (base << UP) >> DN;
        return base[W-1:0];
    endfunction

    // Next-state, datapath iteration and result formatting
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cz_d    = cz_q;
        it_d    = it_q;
        rep_d   = rep_q;
        y_d     = y_q;
        ovr_d   = ovr_q;

        shx       = cx_q >>> it_q;
        shy       = cy_q >>> it_q;
        e_i       = atanh_e(it_q);
        rep_now   = ((it_q == IW'(4)) || (it_q == IW'(13))) && !rep_q;
        last_iter = (it_q == IW'(ITER)) && !rep_now;
        step_z    = cy_q[W-1] ? (cz_q - e_i) : (cz_q + e_i);

        // Round half-up at the guard point, clamp negative residual, saturate.
        z_rnd = step_z + RND;
        z_sh  = z_rnd >> GUARD;
        if (z_rnd[W-1]) begin
            mag_w = '0;
        end else if (z_sh > MAG_MAX) begin
            mag_w = MAG_MAX;
        end else begin
            mag_w = z_sh;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d = x[N-1];
                    if (x[N-2:0] > LIMIT[N-2:0]) begin
                        y_d     = {x[N-1], {(N-1){1'b1}}};
                        ovr_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cx_d       = '0;
                        cx_d[FRAC] = 1'b1;
                        cy_d       = {{(GUARD+2){1'b0}}, x[N-2:0]} << GUARD;
                        cz_d       = '0;
                        it_d       = IW'(1);
                        rep_d      = 1'b0;
                        state_d    = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (cy_q[W-1]) begin
                    cx_d = cx_q + shy;
                    cy_d = cy_q + shx;
                end else begin
                    cx_d = cx_q - shy;
                    cy_d = cy_q - shx;
                end
                cz_d = step_z;
                if (rep_now) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d = 1'b0;
                    it_d  = it_q + IW'(1);
                end
                if (last_iter) begin
                    y_d     = (mag_w[N-2:0] == '0) ? '0 : {sign_q, mag_w[N-2:0]};
                    ovr_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    y_d     = '0;
                    ovr_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            cz_q    <= '0;
            it_q    <= '0;
            rep_q   <= 1'b0;
            y_q     <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cz_q    <= cz_d;
            it_q    <= it_d;
            rep_q   <= rep_d;
            y_q     <= y_d;
            ovr_q   <= ovr_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_atanh_cordic.sv
// Bench for atanh_cordic: real-arithmetic atanh reference with a latency
// model, per-cycle output comparison, directed corner cases and random operands.
module tb_atanh_cordic;

    localparam int LAT = 26;
    localparam int TOL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;
    logic        ovr;

    logic [31:0] lim = 32'h00CE_0000;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic m_valid = 1'b0;
    int   m_left  = 0;
    logic m_ovr   = 1'b0;
    logic m_sign  = 1'b0;
    int   m_exp   = 0;
    int   m_acc   = 0;

    atanh_cordic #(.N(32), .Q(24), .ITER(24), .GUARD(4), .LIMIT(32'h00CE_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    function automatic int ref_mag(input logic [30:0] m);
        real xr, a;
        xr = real'(m) / 16777216.0;
        a  = 0.5 * $ln((1.0 + xr) / (1.0 - xr));
        return $rtoi(a * 16777216.0 + 0.5);
    endfunction

    function automatic int smval(input logic [31:0] v);
        int mag;
        mag = int'({1'b0, v[30:0]});
        return v[31] ? -mag : mag;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_y(input string name, input logic [31:0] act, input int exp);
        int d;
        total++;
        d = smval(act) - exp;
        if (d < 0) d = -d;
        if (d > TOL || act == 32'h8000_0000 || ^act === 1'bx) begin
            bad++;
            $display("FAIL %s: got %h expected %0d (+/-%0d, no negative zero) at %0t",
                     name, act, exp, TOL, $time);
        end
    endtask

    // Behavioural model: acceptance, fixed iteration latency, handshake out
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_left  <= 0;
            m_ovr   <= 1'b0;
            m_sign  <= 1'b0;
            m_exp   <= 0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_valid <= 1'b1;
        end else if (in_valid) begin
            m_acc  <= m_acc + 1;
            m_sign <= x[31];
            if (x[30:0] > lim[30:0]) begin
                m_ovr   <= 1'b1;
                m_valid <= 1'b1;
            end else begin
                m_ovr  <= 1'b0;
                m_left <= LAT;
                m_exp  <= x[31] ? -ref_mag(x[30:0]) : ref_mag(x[30:0]);
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(!m_valid && m_left == 0));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            if (m_ovr) begin
                chk("ovr_y", y, {m_sign, 31'h7FFF_FFFF});
                chk("ovr_flag", 32'(ovr), 32'd1);
            end else begin
                chk_y("y", y, m_exp);
                chk("ovr_flag", 32'(ovr), 32'd0);
            end
        end else begin
            chk("y_idle", y, 32'd0);
            chk("ovr_idle", 32'(ovr), 32'd0);
        end
    end

    task automatic send(input logic [31:0] val, input int hold, input bit keep,
                        input bit lit, input logic [31:0] lit_y);
        int          n;
        int          acc0;
        bit          ov_exp;
        logic [31:0] ys;
        ov_exp   = val[30:0] > lim[30:0];
        acc0     = m_acc;
        x        = val;
        in_valid = 1'b1;
        n = 0;
        while (m_acc == acc0 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (m_acc == acc0) begin
            total++;
            bad++;
            $display("FAIL accept: operand %h not accepted within 200 cycles", val);
            in_valid = 1'b0;
            return;
        end
        if (keep) x = 32'h0100_0000;
        else      in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("latency", 32'(n), ov_exp ? 32'd0 : 32'(LAT));
        if (lit) begin
            if (ov_exp) chk("lit_y", y, lit_y);
            else        chk_y("lit_y", y, smval(lit_y));
            chk("lit_ovr", 32'(ovr), 32'(ov_exp));
        end
        ys = y;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            chk("hold_y", y, ys);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        chk("clr_y", y, 32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        #1 rst_n = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #2;

        // hand-computed values that pin the reference function
        chk("pin_zero", 32'(ref_mag(31'd0)), 32'd0);
        chk_y("pin_half", 32'(ref_mag(31'h0080_0000)), 9215828);
        chk_y("pin_quarter", 32'(ref_mag(31'h0040_0000)), 4285116);

        send(32'h0080_0000, 0, 1'b0, 1'b1, 32'h008C_9F54);
        send(32'h8080_0000, 0, 1'b0, 1'b1, 32'h808C_9F54);
        send(32'h8000_0000, 0, 1'b0, 1'b1, 32'h0000_0000);
        send(32'h0100_0000, 0, 1'b0, 1'b1, 32'h7FFF_FFFF);
        send(32'h8100_0000, 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        send(lim,           2, 1'b0, 1'b0, 32'h0);
        send(lim + 32'd1,   0, 1'b0, 1'b1, 32'h7FFF_FFFF);
        send(32'h0030_0000, 10, 1'b1, 1'b0, 32'h0);

        // asynchronous reset in the middle of an iteration run
        x = 32'h0080_0000;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_y", y, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #2;
        send(32'h0040_0000, 0, 1'b0, 1'b0, 32'h0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0)
                v = {1'b0, 31'($urandom_range(32'h00CE_0001, 32'h7FFF_FFFF))};
            else
                v = {1'b0, 31'($urandom_range(0, 32'h00CE_0000))};
            v[31] = 1'($urandom_range(0, 1));
            send(v, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
